sonar_stream_recorder: RTL and testbench
========================================

Name: sonar_stream_recorder

Overview:
- Synthesizable capture block that sits on a DUT output AXI-Stream and turns each accepted beat into a framed record.
- Records use the same packet/interface/argument-count layout that the sonar exerciser consumes. They are emitted as a 32-bit word stream toward a host or log sink.
- This is the write side of the sonar vector format: the bench reads vectors, and this block produces them from hardware.
- It also emits vector-end records and keeps a running timestamp.

Parameters:
- DATA_WIDTH, 64: monitored tdata width; must be a multiple of 32, range 32..512.
- INTERFACE_ID, 0: 8-bit interface tag written in every record header.
- FIFO_DEPTH, 16: capture FIFO entries; power of 2, minimum 4.
- TS_WIDTH, 32: timestamp counter width, maximum 32.

Ports:
- ap_clk  in  1  single clock.
- ap_rst_n  in  1  asynchronous, active-low reset.
- s_tdata  in  DATA_WIDTH  monitored stream data.
- s_tvalid  in  1  monitored stream valid.
- s_tlast  in  1  monitored stream last.
- s_tready  out  1  capture ready; high when the FIFO is not full.
- vector_end  in  1  single-cycle pulse marking the end of the current test vector.
- vector_id  in  16  vector number, sampled when vector_end is high.
- ts_clear  in  1  clears the timestamp counter to 0 on the next edge.
- m_tdata  out  32  record word stream.
- m_tvalid  out  1  record word valid.
- m_tready  in  1  record sink ready.
- m_tlast  out  1  high on the final word of each record.
- overflow  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values: s_tready=0 while ap_rst_n is low, then 1 on the first edge after release. m_tvalid=0, m_tlast=0, m_tdata=0, overflow=0. Timestamp=0, beat counter=0, FIFO empty.
- Timestamp:
  - Increments by 1 every cycle; wraps from 2^TS_WIDTH-1 to 0.
  - When ts_clear is high, it loads 0 instead of incrementing.
- Capture:
  - A beat is accepted when s_tvalid and s_tready are both high.
  - Each accepted beat writes the entry {tdata, tlast, ts} into the FIFO. ts is the counter value in the accept cycle.
  - The 16-bit beat counter increments on each accept, saturating at 0xFFFF.
- Header word layout: [31:24] type, [23:16] INTERFACE_ID, [15:0] argument word count.
- Beat record (type 0x01):
  - Word count = DATA_WIDTH/32 + 2.
  - Words in order: header; tdata split into 32-bit words, least significant word first; {31'b0, tlast}; ts zero-extended to 32 bits.
- End record (type 0x02):
  - Argument count = 2.
  - Words in order: header; {16'b0, vector_id}; {16'b0, beat counter}.
  - The beat counter resets to 0 in the cycle after the end record's last word is accepted.
- Output handshake:
  - A word transfers when m_tvalid and m_tready are both high.
  - m_tdata, m_tvalid and m_tlast hold stable while m_tready is low.
  - No bubbles between the words of one record when m_tready stays high.
- Latency: a beat accepted at edge N, with the serializer idle and the FIFO empty, presents its header at edge N+2.
- Serializer FSM:
  - IDLE: if the FIFO is not empty, pop the entry and go to HDR. Else if an end is pending, go to EHDR.
  - HDR → DATA (index 0 .. DATA_WIDTH/32-1) → LAST → TS → IDLE.
  - EHDR → EID → ECNT → IDLE; leaving ECNT clears the pending flag.
  - Each state advances only when its word transfers.
- Ordering:
  - A vector_end sets the pending flag. The end record is issued only after every beat accepted before or in the same cycle as vector_end has been serialized.
  - If a beat and vector_end occur in the same cycle, the beat is counted and recorded before the end record.
- Boundary conditions:
  - vector_end while an end is already pending: the new pulse is dropped and overflow is set.
  - FIFO full: s_tready=0, no beat is lost, and overflow is not set (backpressure is legal).
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full and empty are distinguished by the MSB.
  - A simultaneous push and pop while full is not possible, because s_tready=0 when full. Push and pop in the same cycle at any other occupancy keeps the count unchanged.
  - Reset asserted mid-record: outputs return to reset values immediately. The partial record is discarded and the FIFO is emptied.

Decomposition:
- Package sonar_recorder_pkg holds:
  - record type constants: REC_BEAT=8'h01, REC_END=8'h02;
  - the FSM state enum;
  - the header word struct (type, interface, count);
  - a function computing beat argument words from DATA_WIDTH.
- One sub-module: sonar_sync_fifo, a parameterized width/depth FIFO with a registered output and full/empty flags.

Test Plan:
- Single beat: DATA_WIDTH=64, INTERFACE_ID=3, ts_clear pulsed, beat tdata=0x1122334455667788 with tlast=1 accepted at ts=5, m_tready held at 1 → five words: 0x01030004, 0x55667788, 0x11223344, 0x00000001, 0x00000005. m_tlast is high on the fifth word.
- Vector end ordering: 3 beats, then vector_end with vector_id=7 in the same cycle as the third beat → three beat records, then 0x02030002, 0x00000007, 0x00000003. A fourth beat afterwards reports a beat count of 1 in the next end record.
- Backpressure: m_tready=0 while 20 beats are offered with FIFO_DEPTH=16 → s_tready falls after 16 accepts. Releasing m_tready drains all 16 records, in order, with no duplicates; overflow stays 0.
- Output stall: m_tready toggled 1/0 every cycle during a record → m_tdata stays stable while stalled, the record sequence is unchanged, and m_tlast appears once per record.
- Double end: two vector_end pulses two cycles apart while beats are still queued → only one end record is emitted and overflow=1 until reset.
- Async reset mid-record: ap_rst_n driven low during the DATA state, then released → m_tvalid=0 immediately and the FIFO is empty. The first record after release is for a newly accepted beat, and its timestamp restarts from 0.

Source files
------------

// File: rtl/sonar_stream_recorder_pkg.sv
// Shared definitions for the sonar stream recorder: record type codes,
// serializer states, the record header layout and the beat record size.
package sonar_recorder_pkg;

   localparam logic [7:0]  REC_BEAT      = 8'h01;
   localparam logic [7:0]  REC_END       = 8'h02;
   localparam logic [15:0] END_ARG_WORDS = 16'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_LAST,
      ST_TS,
      ST_EHDR,
      ST_EID,
      ST_ECNT
   } rec_state_t;

   typedef struct packed {
      logic [7:0]  rec_type;
      logic [7:0]  iface;
      logic [15:0] arg_words;
   } rec_hdr_t;

   // Argument words following a beat header: the tdata words, tlast and ts.
   function automatic logic [15:0] beat_arg_words(input int unsigned data_width);
      return 16'(data_width / 32 + 2);
   endfunction

endpackage

// File: rtl/sonar_sync_fifo.sv
// Single-clock FIFO with a registered read port. Pointers carry one extra
// bit so that full and empty differ only in the pointer MSB.
module sonar_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             wr_ok, rd_ok;

   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign count = wptr_q - rptr_q;
   assign rd_data = rd_data_q;

   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   // Next pointer values and the word presented on the registered read port.
   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      rd_data_d = rd_data_q;
      if (wr_ok) begin
         wptr_d = wptr_q + (AW+1)'(1);
      end
      if (rd_ok) begin
         rptr_d    = rptr_q + (AW+1)'(1);
         rd_data_d = mem_q[rptr_q[AW-1:0]];
      end
   end

   // Pointers are control state and return to empty on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage and read register carry data only and need no reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wptr_q[AW-1:0]] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

endmodule

// File: rtl/sonar_stream_recorder.sv
// Captures accepted AXI-Stream beats with a timestamp and serializes them,
// together with vector-end markers, into 32-bit framed sonar records.
module sonar_stream_recorder
   import sonar_recorder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter logic [7:0]  INTERFACE_ID = 8'h00,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned TS_WIDTH     = 32
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   input  logic                  vector_end,
   input  logic [15:0]           vector_id,
   input  logic                  ts_clear,
   output logic [31:0]           m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic                  overflow
);

   localparam int unsigned NW         = DATA_WIDTH / 32;
   localparam int unsigned IDX_W      = (NW > 1) ? $clog2(NW) : 1;
   localparam int unsigned ENT_W      = DATA_WIDTH + 1 + TS_WIDTH;
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BEAT_WORDS = beat_arg_words(DATA_WIDTH);
   localparam rec_hdr_t    BEAT_HDR   = '{rec_type: REC_BEAT, iface: INTERFACE_ID, arg_words: BEAT_WORDS};
   localparam rec_hdr_t    END_HDR    = '{rec_type: REC_END, iface: INTERFACE_ID, arg_words: END_ARG_WORDS};

   logic [TS_WIDTH-1:0]   ts_q, ts_d;
   logic                  rdy_q, rdy_d;
   logic [15:0]           beat_cnt_q, beat_cnt_d;
   logic                  pend_q, pend_d;
   logic [15:0]           vid_q, vid_d;
   logic                  ovf_q, ovf_d;
   rec_state_t            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [31:0]           m_tdata_q, m_tdata_d;
   logic                  m_tvalid_q, m_tvalid_d;
   logic                  m_tlast_q, m_tlast_d;
   logic                  m_end_q, m_end_d;

   logic [ENT_W-1:0]      rd_entry;
   logic                  f_full, f_empty;
   logic [CNT_W-1:0]      f_count;
   logic                  pop, accept, holding, cap_full;
   logic                  out_free, end_done, pend_clr;
   logic                  word_vld, word_last, word_end;
   logic [31:0]           word;
   logic [DATA_WIDTH-1:0] ent_data;
   logic                  ent_last;
   logic [TS_WIDTH-1:0]   ent_ts;
   logic [31:0]           data_words [2**IDX_W];

   // The entry being serialized still occupies a capture slot, so total
   // buffering (FIFO plus the popped entry) never exceeds FIFO_DEPTH.
   assign holding  = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                     (state_q == ST_LAST) || (state_q == ST_TS);
   assign cap_full = f_full || (holding && (f_count == CNT_W'(FIFO_DEPTH - 1)));
   assign s_tready = rdy_q && !cap_full;
   assign accept   = s_tvalid && s_tready;

   sonar_sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (ap_clk),
      .rst_n   (ap_rst_n),
      .wr_en   (accept),
      .wr_data ({s_tdata, s_tlast, ts_q}),
      .rd_en   (pop),
      .rd_data (rd_entry),
      .full    (f_full),
      .empty   (f_empty),
      .count   (f_count)
   );

   assign ent_data = rd_entry[ENT_W-1 -: DATA_WIDTH];
   assign ent_last = rd_entry[TS_WIDTH];
   assign ent_ts   = rd_entry[TS_WIDTH-1:0];

   // tdata split into 32-bit words, least significant first; padded to a power of 2.
   for (genvar g = 0; g < 2**IDX_W; g++) begin : g_split
      if (g < NW) begin : g_word
         assign data_words[g] = ent_data[g*32 +: 32];
      end else begin : g_pad
         assign data_words[g] = '0;
      end
   end

   // The output register can take a new word when empty or draining this cycle.
   assign out_free = !m_tvalid_q || m_tready;
   assign end_done = m_tvalid_q && m_tready && m_tlast_q && m_end_q;

   assign m_tdata  = m_tdata_q;
   assign m_tvalid = m_tvalid_q;
   assign m_tlast  = m_tlast_q;
   assign overflow = ovf_q;

   // Serializer next state: pick the word for the current state and advance
   // once the output register accepts it.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pop       = 1'b0;
      pend_clr  = 1'b0;
      word_vld  = 1'b0;
      word_last = 1'b0;
      word_end  = 1'b0;
      word      = '0;
      case (state_q)
         ST_IDLE: begin
            if (!f_empty) begin
               pop     = 1'b1;
               state_d = ST_HDR;
            end else if (pend_q) begin
               state_d = ST_EHDR;
            end
         end
         ST_HDR: begin
            word_vld = 1'b1;
            word     = BEAT_HDR;
            if (out_free) begin
               idx_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            word_vld = 1'b1;
            word     = data_words[idx_q];
            if (out_free) begin
               if (idx_q == IDX_W'(NW - 1)) begin
                  state_d = ST_LAST;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_LAST: begin
            word_vld = 1'b1;
            word     = {31'b0, ent_last};
            if (out_free) begin
               state_d = ST_TS;
            end
         end
         ST_TS: begin
            word_vld  = 1'b1;
            word_last = 1'b1;
            word      = 32'(ent_ts);
            if (out_free) begin
               state_d = ST_IDLE;
            end
         end
         ST_EHDR: begin
            word_vld = 1'b1;
            word     = END_HDR;
            if (out_free) begin
               state_d = ST_EID;
            end
         end
         ST_EID: begin
            word_vld = 1'b1;
            word     = {16'b0, vid_q};
            if (out_free) begin
               state_d = ST_ECNT;
            end
         end
         ST_ECNT: begin
            word_vld  = 1'b1;
            word_last = 1'b1;
            word_end  = 1'b1;
            word      = {16'b0, beat_cnt_q};
            if (out_free) begin
               pend_clr = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output register: holds its word while stalled, reloads when free.
   always_comb begin
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tlast_d  = m_tlast_q;
      m_end_d    = m_end_q;
      if (out_free) begin
         m_tvalid_d = word_vld;
         m_tlast_d  = word_vld && word_last;
         m_end_d    = word_vld && word_end;
         if (word_vld) begin
            m_tdata_d = word;
         end
      end
   end

   // Timestamp, beat counter, vector-end pending flag and overflow.
   always_comb begin
      rdy_d      = 1'b1;
      ts_d       = ts_clear ? '0 : ts_q + TS_WIDTH'(1);
      beat_cnt_d = beat_cnt_q;
      pend_d     = pend_q;
      vid_d      = vid_q;
      ovf_d      = ovf_q;
      if (end_done) begin
         // A beat landing on the clearing edge starts the next vector's count.
         beat_cnt_d = accept ? 16'd1 : 16'd0;
      end else if (accept && (beat_cnt_q != 16'hFFFF)) begin
         beat_cnt_d = beat_cnt_q + 16'd1;
      end
      if (pend_clr) begin
         pend_d = 1'b0;
      end
      if (vector_end) begin
         if (pend_q && !pend_clr) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = 1'b1;
            vid_d  = vector_id;
         end
      end
   end

   // All recorder state returns to its idle values on reset.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ts_q       <= '0;
         rdy_q      <= 1'b0;
         beat_cnt_q <= '0;
         pend_q     <= 1'b0;
         vid_q      <= '0;
         ovf_q      <= 1'b0;
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_end_q    <= 1'b0;
      end else begin
         ts_q       <= ts_d;
         rdy_q      <= rdy_d;
         beat_cnt_q <= beat_cnt_d;
         pend_q     <= pend_d;
         vid_q      <= vid_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
         m_tdata_q  <= m_tdata_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         m_end_q    <= m_end_d;
      end
   end

endmodule

// File: tb/tb_sonar_stream_recorder.sv
// Directed bench for sonar_stream_recorder (DATA_WIDTH=64, INTERFACE_ID=3).
module tb_sonar_stream_recorder;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic [63:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic        s_tready;
   logic        vector_end = 1'b0;
   logic [15:0] vector_id = '0;
   logic        ts_clear = 1'b0;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        m_tlast;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] got_w [$];
   logic        got_l [$];
   logic [31:0] exp_w [$];
   logic        exp_l [$];
   logic [63:0] bd [16];
   logic        bl [16];

   sonar_stream_recorder #(
      .DATA_WIDTH   (64),
      .INTERFACE_ID (8'd3),
      .FIFO_DEPTH   (16),
      .TS_WIDTH     (32)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tlast    (s_tlast),
      .s_tready   (s_tready),
      .vector_end (vector_end),
      .vector_id  (vector_id),
      .ts_clear   (ts_clear),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .overflow   (overflow)
   );

   always #5 ap_clk = ~ap_clk;

   // Record every word that will transfer on the coming rising edge.
   always @(negedge ap_clk) begin
      if (ap_rst_n && m_tvalid && m_tready) begin
         got_w.push_back(m_tdata);
         got_l.push_back(m_tlast);
      end
   end

   task automatic tick;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic wait_words(input int n, input int budget, output bit ok);
      int c = 0;
      while (got_w.size() < n && c < budget) begin
         tick();
         c++;
      end
      ok = (got_w.size() >= n);
   endtask

   function automatic void add_beat(input logic [63:0] d, input logic l, input logic [31:0] ts);
      exp_w.push_back(32'h0103_0004); exp_l.push_back(1'b0);
      exp_w.push_back(d[31:0]);       exp_l.push_back(1'b0);
      exp_w.push_back(d[63:32]);      exp_l.push_back(1'b0);
      exp_w.push_back({31'b0, l});    exp_l.push_back(1'b0);
      exp_w.push_back(ts);            exp_l.push_back(1'b1);
   endfunction

   function automatic void add_end(input logic [15:0] vid, input logic [15:0] cnt);
      exp_w.push_back(32'h0203_0002); exp_l.push_back(1'b0);
      exp_w.push_back({16'b0, vid});  exp_l.push_back(1'b0);
      exp_w.push_back({16'b0, cnt});  exp_l.push_back(1'b1);
   endfunction

   task automatic do_reset;
      s_tvalid = 1'b0; s_tlast = 1'b0; vector_end = 1'b0; ts_clear = 1'b0; m_tready = 1'b1;
      ap_rst_n = 1'b0;
      tick();
      tick();
      ap_rst_n = 1'b1;
      tick();
      got_w.delete(); got_l.delete();
      exp_w.delete(); exp_l.delete();
   endtask

   // Beats from bd/bl on consecutive cycles; with clr the first beat gets ts=0.
   task automatic send_beats(input int n, input bit clr, input bit with_end, input logic [15:0] vid);
      if (clr) begin
         ts_clear = 1'b1;
         tick();
         ts_clear = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         s_tvalid = 1'b1; s_tdata = bd[i]; s_tlast = bl[i];
         if (with_end && i == n - 1) begin
            vector_end = 1'b1; vector_id = vid;
         end
         tick();
         vector_end = 1'b0;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic test_reset;
      tick();
      tick();
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b expected 0", s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast: got %b expected 0", m_tlast); end
      checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset_m_tdata: got %h expected 0", m_tdata); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      ap_rst_n = 1'b1;
      #1;
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL release_s_tready_pre_edge: got %b expected 0", s_tready); end
      tick();
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL release_s_tready: got %b expected 1", s_tready); end
      got_w.delete(); got_l.delete();
   endtask

   task automatic test_single_beat;
      bit ok;
      exp_w.delete(); exp_l.delete();
      ts_clear = 1'b1;
      tick();
      ts_clear = 1'b0;
      repeat (5) tick();
      s_tvalid = 1'b1; s_tdata = 64'h1122_3344_5566_7788; s_tlast = 1'b1;
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", s_tready); end
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_latency_n: got valid %b expected 0", m_tvalid); end
      tick();
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL single_latency_n1: got valid %b expected 0", m_tvalid); end
      tick();
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h0103_0004) begin
         errors++; $display("FAIL single_latency_n2: got valid %b data %h expected 1 01030004", m_tvalid, m_tdata);
      end
      add_beat(64'h1122_3344_5566_7788, 1'b1, 32'd5);
      wait_words(5, 40, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL single_timeout: got %0d words expected 5", got_w.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            logic [31:0] gw; logic gl;
            gw = got_w.pop_front(); gl = got_l.pop_front();
            checks++;
            if (gw !== exp_w[i] || gl !== exp_l[i]) begin
               errors++; $display("FAIL single_word%0d: got %h last %b expected %h last %b", i, gw, gl, exp_w[i], exp_l[i]);
            end
         end
      end
   endtask

   task automatic test_vector_end;
      bit ok;
      do_reset();
      bd[0] = 64'hDEAD_BEEF_0000_0001; bl[0] = 1'b0;
      bd[1] = 64'hCAFE_F00D_0000_0002; bl[1] = 1'b0;
      bd[2] = 64'h0123_4567_89AB_CDEF; bl[2] = 1'b1;
      send_beats(3, 1'b1, 1'b1, 16'd7);
      add_beat(bd[0], 1'b0, 32'd0);
      add_beat(bd[1], 1'b0, 32'd1);
      add_beat(bd[2], 1'b1, 32'd2);
      add_end(16'd7, 16'd3);
      wait_words(18, 100, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL vend_timeout: got %0d words expected 18", got_w.size());
      end else begin
         for (int i = 0; i < 18; i++) begin
            logic [31:0] gw; logic gl;
            gw = got_w.pop_front(); gl = got_l.pop_front();
            checks++;
            if (gw !== exp_w[i] || gl !== exp_l[i]) begin
               errors++; $display("FAIL vend_word%0d: got %h last %b expected %h last %b", i, gw, gl, exp_w[i], exp_l[i]);
            end
         end
      end
      exp_w.delete(); exp_l.delete();
      bd[0] = 64'h0F0F_0F0F_F0F0_F0F0; bl[0] = 1'b1;
      send_beats(1, 1'b1, 1'b1, 16'd9);
      add_beat(bd[0], 1'b1, 32'd0);
      add_end(16'd9, 16'd1);
      wait_words(8, 60, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL vend2_timeout: got %0d words expected 8", got_w.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            logic [31:0] gw; logic gl;
            gw = got_w.pop_front(); gl = got_l.pop_front();
            checks++;
            if (gw !== exp_w[i] || gl !== exp_l[i]) begin
               errors++; $display("FAIL vend2_word%0d: got %h last %b expected %h last %b", i, gw, gl, exp_w[i], exp_l[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      int acc = 0;
      bit will;
      do_reset();
      m_tready = 1'b0;
      ts_clear = 1'b1;
      tick();
      ts_clear = 1'b0;
      for (int c = 0; c < 20; c++) begin
         s_tvalid = 1'b1;
         s_tdata  = {32'hC0DE_0000 + 32'(acc), 32'h0000_5A00 + 32'(acc)};
         s_tlast  = acc[0];
         will = s_tready;
         tick();
         if (will) acc++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      checks++; if (acc != 16) begin errors++; $display("FAIL bp_accepts: got %0d expected 16", acc); end
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", s_tready); end
      for (int i = 0; i < 16; i++) begin
         logic [31:0] iv;
         iv = 32'(i);
         add_beat({32'hC0DE_0000 + iv, 32'h0000_5A00 + iv}, iv[0], iv);
      end
      m_tready = 1'b1;
      wait_words(80, 400, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL bp_timeout: got %0d words expected 80", got_w.size());
      end else begin
         for (int i = 0; i < 80; i++) begin
            logic [31:0] gw; logic gl;
            gw = got_w.pop_front(); gl = got_l.pop_front();
            checks++;
            if (gw !== exp_w[i] || gl !== exp_l[i]) begin
               errors++; $display("FAIL bp_word%0d: got %h last %b expected %h last %b", i, gw, gl, exp_w[i], exp_l[i]);
            end
         end
      end
      repeat (20) tick();
      checks++; if (got_w.size() != 0) begin errors++; $display("FAIL bp_extra_words: got %0d expected 0", got_w.size()); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_output_stall;
      bit ok;
      logic pv, pr;
      logic [31:0] pd;
      int nlast = 0;
      do_reset();
      m_tready = 1'b0;
      bd[0] = 64'hAAAA_5555_1234_5678; bl[0] = 1'b1;
      bd[1] = 64'h0000_FFFF_8765_4321; bl[1] = 1'b0;
      send_beats(2, 1'b1, 1'b0, 16'd0);
      pv = 1'b0; pr = 1'b1; pd = '0;
      for (int c = 0; c < 40; c++) begin
         if (pv && !pr) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== pd) begin
               errors++; $display("FAIL stall_hold cycle %0d: got valid %b data %h expected 1 %h", c, m_tvalid, m_tdata, pd);
            end
         end
         pv = m_tvalid; pd = m_tdata;
         m_tready = c[0];
         pr = m_tready;
         tick();
      end
      m_tready = 1'b1;
      add_beat(bd[0], 1'b1, 32'd0);
      add_beat(bd[1], 1'b0, 32'd1);
      wait_words(10, 60, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL stall_timeout: got %0d words expected 10", got_w.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            logic [31:0] gw; logic gl;
            gw = got_w.pop_front(); gl = got_l.pop_front();
            if (gl === 1'b1) nlast++;
            checks++;
            if (gw !== exp_w[i] || gl !== exp_l[i]) begin
               errors++; $display("FAIL stall_word%0d: got %h last %b expected %h last %b", i, gw, gl, exp_w[i], exp_l[i]);
            end
         end
         checks++;
         if (nlast != 2) begin errors++; $display("FAIL stall_tlast_count: got %0d expected 2", nlast); end
      end
   endtask

   task automatic test_double_end;
      bit ok;
      do_reset();
      m_tready = 1'b0;
      bd[0] = 64'h1111_1111_2222_2222; bl[0] = 1'b0;
      bd[1] = 64'h3333_3333_4444_4444; bl[1] = 1'b0;
      bd[2] = 64'h5555_5555_6666_6666; bl[2] = 1'b1;
      send_beats(3, 1'b1, 1'b0, 16'd0);
      vector_end = 1'b1; vector_id = 16'h0011;
      tick();
      vector_end = 1'b0;
      tick();
      vector_end = 1'b1; vector_id = 16'h0022;
      tick();
      vector_end = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL dend_overflow: got %b expected 1", overflow); end
      add_beat(bd[0], 1'b0, 32'd0);
      add_beat(bd[1], 1'b0, 32'd1);
      add_beat(bd[2], 1'b1, 32'd2);
      add_end(16'h0011, 16'd3);
      m_tready = 1'b1;
      wait_words(18, 100, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL dend_timeout: got %0d words expected 18", got_w.size());
      end else begin
         for (int i = 0; i < 18; i++) begin
            logic [31:0] gw; logic gl;
            gw = got_w.pop_front(); gl = got_l.pop_front();
            checks++;
            if (gw !== exp_w[i] || gl !== exp_l[i]) begin
               errors++; $display("FAIL dend_word%0d: got %h last %b expected %h last %b", i, gw, gl, exp_w[i], exp_l[i]);
            end
         end
      end
      repeat (30) tick();
      checks++; if (got_w.size() != 0) begin errors++; $display("FAIL dend_second_record: got %0d words expected 0", got_w.size()); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL dend_sticky: got %b expected 1", overflow); end
      do_reset();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dend_reset_clear: got %b expected 0", overflow); end
   endtask

   task automatic test_async_reset;
      bit ok;
      do_reset();
      bd[0] = 64'h89AB_CDEF_7654_3210; bl[0] = 1'b1;
      send_beats(1, 1'b1, 1'b0, 16'd0);
      wait_words(1, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL arst_header_timeout: got %0d words expected 1", got_w.size()); end
      ap_rst_n = 1'b0;
      #1;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL arst_m_tvalid: got %b expected 0", m_tvalid); end
      checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL arst_m_tdata: got %h expected 0", m_tdata); end
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL arst_s_tready: got %b expected 0", s_tready); end
      got_w.delete(); got_l.delete();
      exp_w.delete(); exp_l.delete();
      tick();
      ap_rst_n = 1'b1;
      repeat (10) tick();
      checks++; if (got_w.size() != 0) begin errors++; $display("FAIL arst_residue: got %0d words expected 0", got_w.size()); end
      bd[0] = 64'h0000_0000_0000_ABCD; bl[0] = 1'b0;
      send_beats(1, 1'b0, 1'b0, 16'd0);
      add_beat(bd[0], 1'b0, 32'd10);
      wait_words(5, 40, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL arst_timeout: got %0d words expected 5", got_w.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            logic [31:0] gw; logic gl;
            gw = got_w.pop_front(); gl = got_l.pop_front();
            checks++;
            if (gw !== exp_w[i] || gl !== exp_l[i]) begin
               errors++; $display("FAIL arst_word%0d: got %h last %b expected %h last %b", i, gw, gl, exp_w[i], exp_l[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_vector_end();
      test_backpressure();
      test_output_stall();
      test_double_end();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
